// File: rtl/hadamard_input_packer_if.sv
// Sample stream into the Hadamard input packer: one complex SFP sample per beat.
interface hadamard_input_packer_if #(
    parameter int formatWidth = 9
);
    logic                   in_valid;
    logic                   in_ready;
    logic [formatWidth-1:0] in_real;
    logic [formatWidth-1:0] in_imag;
    logic                   in_last;

    modport master (output in_valid, in_real, in_imag, in_last, input  in_ready);
    modport slave  (input  in_valid, in_real, in_imag, in_last, output in_ready);
endinterface

// File: rtl/hadamard_input_packer.sv
// Packs four complex SFP samples into lane vectors via ping-pong buffers, fetches
// the matching twiddle set from a synchronous ROM and launches the Hadamard stage.
module hadamard_input_packer #(
    parameter int formatWidth = 9,
    parameter int GROUPS      = 4,
    parameter int twAddrWidth = 2,
    parameter int LATENCY     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    hadamard_input_packer_if.slave     smp,
    output logic                       tw_en,
    output logic [twAddrWidth-1:0]     tw_addr,
    input  logic [formatWidth*4-1:0]   tw_rom_real,
    input  logic [formatWidth*4-1:0]   tw_rom_imag,
    output logic                       start,
    output logic [formatWidth*4-1:0]   input_real,
    output logic [formatWidth*4-1:0]   input_imag,
    output logic [formatWidth*4-1:0]   twiddle_real,
    output logic [formatWidth*4-1:0]   twiddle_imag,
    output logic                       group_valid,
    output logic                       frame_err
);
    localparam int W = formatWidth;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

    state_t                 state;
    logic                   ready_en;
    logic [1:0]             full;
    logic [1:0]             last_flag;
    logic [1:0]             short_flag;
    logic                   fill_sel;
    logic                   issue_sel;
    logic [1:0]             lane;
    logic [twAddrWidth-1:0] group_cnt;
    logic [LATENCY-1:0]     lat_sr;
    logic [4*W-1:0]         buf_re [2];
    logic [4*W-1:0]         buf_im [2];

    logic                   accept;
    logic                   complete;
    logic                   is_short;
    logic [twAddrWidth-1:0] gcnt_next;
    logic                   issue_err;

    assign smp.in_ready = ready_en & ~full[fill_sel];
    assign accept       = smp.in_valid & smp.in_ready;
    assign complete     = accept & ((lane == 2'd3) | smp.in_last);
    assign is_short     = accept & smp.in_last & (lane != 2'd3);
    assign group_valid  = lat_sr[LATENCY-1];

    // A short group already flagged its error on accept, so its issue stays silent.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        gcnt_next = group_cnt + twAddrWidth'(1);
        issue_err = 1'b0;
        if (last_flag[issue_sel] || group_cnt == twAddrWidth'(GROUPS-1))
            gcnt_next = '0;
        if (last_flag[issue_sel] && !short_flag[issue_sel] &&
            group_cnt != twAddrWidth'(GROUPS-1))
            issue_err = 1'b1;
    end

    // NOTE: buffer storage has no reset; the full flags gate every use, so stale lanes are never issued.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 4; k++) begin
                if (k == int'(lane)) begin
                    buf_re[fill_sel][W*k +: W] <= smp.in_real;
                    buf_im[fill_sel][W*k +: W] <= smp.in_imag;
                end else if (smp.in_last && k > int'(lane)) begin
                    buf_re[fill_sel][W*k +: W] <= '0;
                    buf_im[fill_sel][W*k +: W] <= '0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ready_en     <= 1'b0;
            full         <= '0;
            last_flag    <= '0;
            short_flag   <= '0;
            fill_sel     <= 1'b0;
            issue_sel    <= 1'b0;
            lane         <= '0;
            group_cnt    <= '0;
            lat_sr       <= '0;
            tw_en        <= 1'b0;
            tw_addr      <= '0;
            start        <= 1'b0;
            input_real   <= '0;
            input_imag   <= '0;
            twiddle_real <= '0;
            twiddle_imag <= '0;
            frame_err    <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            start     <= 1'b0;
            tw_en     <= 1'b0;
            frame_err <= is_short;
            lat_sr    <= {lat_sr[LATENCY-2:0], start};

            if (accept)
                lane <= complete ? 2'd0 : lane + 2'd1;
            if (complete) begin
                full[fill_sel]       <= 1'b1;
                last_flag[fill_sel]  <= smp.in_last;
                short_flag[fill_sel] <= is_short;
                fill_sel             <= ~fill_sel;
            end

            case (state)
                S_IDLE: begin
                    if (full[issue_sel]) begin
                        state   <= S_FETCH;
                        tw_en   <= 1'b1;
                        tw_addr <= group_cnt;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    input_real      <= buf_re[issue_sel];
                    input_imag      <= buf_im[issue_sel];
                    twiddle_real    <= tw_rom_real;
                    twiddle_imag    <= tw_rom_imag;
                    start           <= 1'b1;
                    full[issue_sel] <= 1'b0;
                    issue_sel       <= ~issue_sel;
                    group_cnt       <= gcnt_next;
                    if (issue_err)
                        frame_err <= 1'b1;
                    if (full[~issue_sel]) begin
                        state   <= S_FETCH;
                        tw_en   <= 1'b1;
                        tw_addr <= gcnt_next;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/hadamard_input_packer.md
Name: hadamard_input_packer

Overview:
- Upstream feeder for complexhadamard in the FFT pipeline.
- Accepts one complex SFP sample per cycle over a valid/ready handshake and packs four samples into a lane vector.
- Fetches the matching four twiddle factors from an external synchronous twiddle ROM, then presents input and twiddle vectors to the Hadamard stage with a one-cycle start pulse.
- Tracks the downstream pipeline latency and flags when the Hadamard outputs are valid.

Parameters:
- formatWidth, 9: SFP word width (sign, exponent, mantissa).
- GROUPS, 4: groups of 4 samples per FFT frame, i.e. the number of twiddle sets.
- twAddrWidth, 2: width of the twiddle ROM address; GROUPS ≤ 2^twAddrWidth.
- LATENCY, 5: cycles from start to valid Hadamard output registers.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: sample valid.
- in_ready, output, 1: packer can accept a sample.
- in_real, input, formatWidth: sample real part (SFP).
- in_imag, input, formatWidth: sample imaginary part (SFP).
- in_last, input, 1: last sample of the frame.
- tw_en, output, 1: twiddle ROM read enable.
- tw_addr, output, twAddrWidth: twiddle ROM address (group index).
- tw_rom_real, input, formatWidth*4: ROM real data, valid 1 cycle after tw_en.
- tw_rom_imag, input, formatWidth*4: ROM imaginary data, same timing.
- start, output, 1: one-cycle pulse when a new group is presented.
- input_real, output, formatWidth*4: packed real lanes to the Hadamard stage.
- input_imag, output, formatWidth*4: packed imaginary lanes.
- twiddle_real, output, formatWidth*4: packed twiddle real lanes.
- twiddle_imag, output, formatWidth*4: packed twiddle imaginary lanes.
- group_valid, output, 1: Hadamard outputs valid for the group started LATENCY cycles earlier.
- frame_err, output, 1: one-cycle pulse on a framing error.

Behaviour:
- Reset (async, rst=0):
  - All outputs 0, except in_ready=0 while rst=0 and 1 on the first cycle after release.
  - Both buffers empty; lane and group counters 0; FSM IDLE; latency shift register cleared.
  - Reset mid-operation discards partial and pending groups with no start issued.
- Buffering:
  - Two ping-pong buffers A/B, each holding 4 complex lanes. Filling begins in A.
  - A sample is accepted when in_valid & in_ready. Lane k of the current group goes to bits [formatWidth*(k+1)-1 : formatWidth*k].
  - Lane counter 0..3.
  - A buffer becomes full on the lane-3 accept, or on an in_last accept at lane <3. In the latter case the remaining lanes are zero-filled and frame_err pulses next cycle.
  - A full buffer is queued for issue; filling switches to the other buffer.
  - in_ready = fill buffer empty. in_ready drops only when both buffers are full or awaiting issue.
- Issue FSM (IDLE → FETCH → WAIT):
  - IDLE: go to FETCH when any buffer is full; buffers are issued in fill order.
  - FETCH (1 cycle): tw_en=1, tw_addr=group_cnt.
  - WAIT (1 cycle): ROM data is present. At the closing edge:
    - input_* ← buffer; twiddle_* ← ROM data;
    - start ← 1 for exactly one cycle;
    - buffer freed; group_cnt updated.
  - After WAIT, go to FETCH if the other buffer is full, else IDLE.
- Timing and throughput:
  - start is high 3 cycles after the edge that completed the buffer.
  - Sustained throughput: 1 sample/cycle.
  - Packed outputs hold until the next start (≥2 cycles apart, ≥4 in streaming).
- group_cnt update:
  - Increments modulo GROUPS.
  - Forced to 0 if the issued group carried in_last.
  - in_last on a group with group_cnt ≠ GROUPS-1 also pulses frame_err and resets group_cnt to 0.
  - Wrap past GROUPS-1 without in_last is legal; no error.
- group_valid: start delayed by exactly LATENCY cycles through a shift register; groups may overlap in flight.
- Simultaneous events:
  - Accept into one buffer while the FSM frees the other is legal in the same cycle.
  - A freed buffer is fillable on the following cycle.
  - Two frame_err causes in the same group produce one pulse.

Test Plan:
- Reset, then stream 16 samples (values 1..16 encoded), in_valid=1 continuously, in_last on #16, GROUPS=4:
  - in_ready stays 1.
  - 4 start pulses, each 3 cycles after lanes complete.
  - tw_addr sequence 0,1,2,3.
  - Lane 0 of group 0 = sample 1.
  - group_valid pulses exactly 5 cycles after each start.
- ROM model returning addr-tagged words → twiddle_real/imag for each group equal the ROM word at its address; hold stable until the next start.
- in_last on sample 2 of a group → lanes 2,3 zero, frame_err one pulse, next group uses tw_addr 0.
- Three back-to-back single-sample frames (in_last every sample) → in_ready drops for at least one cycle; all 3 groups issue in order with no sample lost.
- Assert rst mid-fill (lane 2) and while in WAIT → all outputs 0 and no start. After release, a new 4-sample group issues at tw_addr 0.
- 20 groups without in_last, GROUPS=4 → tw_addr wraps 0..3 repeatedly; frame_err never asserts.
